sda_kernel_run_ctrl: RTL and testbench
======================================

# sda_kernel_run_ctrl

Kernel run controller for an SDAccel kernel wrapper. It implements the host-visible control/status, interrupt-enable and interrupt-status registers behind the single-cycle register request port. It sequences the action core through its SELF go/done four-phase handshakes, including auto-restart, and drives the kernel `interrupt` output. It sits between the AXI slave register selector and the generated action top.

## Interface
- `REG_ADDR_WIDTH`, 3: word address width of the register port; only word addresses 0–4 are implemented.
- `ap_clk`  in  1  kernel clock; all state changes on its rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `reg_req`  in  1  register access request; held high until `reg_ack`.
- `reg_ack`  out  1  one-cycle acknowledge.
- `reg_write_en`  in  1  1 = write, 0 = read; qualified by `reg_req`.
- `reg_addr`  in  REG_ADDR_WIDTH  word address.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data; valid only while `reg_ack`=1, 0 otherwise.
- `go_0r`  out  1  go request to the action core.
- `go_0a`  in  1  go acknowledge from the action core.
- `done_0r`  in  1  done request from the action core.
- `done_0a`  out  1  done acknowledge to the action core.
- `interrupt`  out  1  level interrupt to the shell.

## Operation
- **Register map (word address)**
  - 0 CTRL: bit0 ap_start (W1S; reads 1 from set until ap_ready); bit1 ap_done (RO, clear-on-read); bit2 ap_idle (RO); bit3 ap_ready (RO, clear-on-read); bit7 auto_restart (RW); other bits read 0.
  - 1 GIE: bit0 RW.
  - 2 IER: bit0 done enable, bit1 ready enable; RW.
  - 3 ISR: bit0 done, bit1 ready; write-1-toggles.
  - 4 RUNCYC: RO cycle count of the current or last run.
  - 5–7: read 0; writes ignored.
- **Register access**
  - `reg_req` is sampled at edge E. `reg_ack` and `reg_rdata` are driven high/valid for the cycle after E.
  - The write takes effect at E. Clear-on-read also takes effect at E.
  - A new request is accepted only after `reg_ack` falls; a request held high during the ack cycle is not re-serviced.
- **FSM states:** IDLE, GO_REQ, GO_RTZ, WAIT_DONE, DONE_ACK, DONE_RTZ.
  - IDLE→GO_REQ when ap_start=1.
  - GO_REQ (`go_0r`=1)→GO_RTZ when `go_0a`=1.
  - GO_RTZ (`go_0r`=0)→WAIT_DONE when `go_0a`=0.
  - WAIT_DONE→DONE_ACK when `done_0r`=1.
  - DONE_ACK (`done_0a`=1)→DONE_RTZ when `done_0r`=0.
  - Leaving DONE_RTZ (`done_0a`=0) on the next edge:
    - sets ap_done, ap_ready, ISR[0] and ISR[1];
    - clears ap_start;
    - goes to GO_REQ if auto_restart=1 (ap_start stays 1), else to IDLE.
- **Status and counters**
  - ap_idle = (state==IDLE).
  - `done_0r` is ignored outside WAIT_DONE. An early assertion is held by the action core and is serviced on entering WAIT_DONE.
  - RUNCYC is cleared on entry to GO_REQ and increments every cycle the FSM is not IDLE. It saturates at 0xFFFF_FFFF.
- **Interrupt:** `interrupt` is registered: GIE & |(ISR & IER).
- **Simultaneous events**
  - A hardware set of ap_done/ap_ready in the same cycle as a clear-on-read: the set wins. The read returns the pre-edge value and the bit stays 1.
  - An ISR hardware set in the same cycle as a toggle write to that bit: the set wins.
  - Writing ap_start=1 while not IDLE is ignored. Writing ap_start=0 has no effect.
  - Clearing auto_restart mid-run takes effect at the end of the current run.

## Timing
- **Reset:** asserting `ap_rst_n`=0 at any time, including mid-handshake, immediately forces:
  - `go_0r`, `done_0a`, `reg_ack`, `interrupt` = 0; `reg_rdata` = 0;
  - FSM to IDLE;
  - all registers to 0 (ap_idle reads 1).
- **Start latency:** ap_start write at edge E0 → FSM in GO_REQ after E1 → `go_0r`=1 from E1.
- **Handshake response:** each transition is one edge after the sampled input condition; `go_0r` and `done_0a` are registered FSM outputs.
- **Done-to-IDLE:** `done_0r` falls, sampled at edge F; `done_0a`=0 from F; ap_done=1 and FSM IDLE from F+1; `interrupt` rises at F+2 if enabled.
- **Register read latency:** 1 cycle, fixed.

## Test plan
- Reset release, read addr 0 → `reg_rdata`=0x0000_0004; addr 4 → 0; `go_0r`=0, `interrupt`=0.
- Write 0x1 to addr 0; action core acks `go_0a` 2 cycles later and raises `done_0r` 10 cycles after `go_0a` falls. Required:
  - full go/done four-phase sequence;
  - CTRL reads 0x0E;
  - a second CTRL read returns 0x04;
  - RUNCYC equals the measured non-IDLE cycle count.
- GIE=1, IER=0x1, run once → `interrupt`=1 two edges after DONE_RTZ exit; write ISR=0x1 → `interrupt`=0 next cycle; write ISR=0x1 again → interrupt reasserts.
- auto_restart=1 with start, three runs → `go_0r` re-asserts one edge after each DONE_RTZ exit and ap_idle stays 0. Then clear auto_restart → IDLE after the current run completes.
- CTRL read issued in the exact cycle ap_done is set → read returns bit1=0 and the next read returns bit1=1.
- Assert `ap_rst_n` while in DONE_ACK → `done_0a`=0 immediately; after release, ap_idle=1 and a new start completes normally.

Source files
------------

// File: rtl/sda_kernel_run_ctrl.sv
// Kernel run controller: host control/status/interrupt registers plus the
// SELF go/done four-phase sequencer for the action core.
module sda_kernel_run_ctrl #(
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      reg_req,
  output logic                      reg_ack,
  input  logic                      reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic                      go_0r,
  input  logic                      go_0a,
  input  logic                      done_0r,
  output logic                      done_0a,
  output logic                      interrupt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO_REQ,
    S_GO_RTZ,
    S_WAIT_DONE,
    S_DONE_ACK,
    S_DONE_RTZ
  } state_e;

  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CTRL   = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_GIE    = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_IER    = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ISR    = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_RUNCYC = REG_ADDR_WIDTH'(4);

  state_e      state_q, state_d;
  logic        ap_start_q, ap_start_d;
  logic        ap_done_q, ap_done_d;
  logic        ap_ready_q, ap_ready_d;
  logic        auto_restart_q, auto_restart_d;
  logic        gie_q, gie_d;
  logic [1:0]  ier_q, ier_d;
  logic [1:0]  isr_q, isr_d;
  logic [31:0] runcyc_q, runcyc_d;
  logic        reg_ack_q, reg_ack_d;
  logic [31:0] reg_rdata_q, reg_rdata_d;
  logic        go_0r_q, done_0a_q, interrupt_q;

  logic        reg_accept, reg_wr, reg_rd, run_end;
  logic        unused_wdata;

  assign unused_wdata = ^{reg_wdata[31:8], reg_wdata[6:2]};

  // One access per ack: a request still held during the ack cycle is ignored.
  assign reg_accept = reg_req & ~reg_ack_q;
  assign reg_wr     = reg_accept & reg_write_en;
  assign reg_rd     = reg_accept & ~reg_write_en;
  assign run_end    = (state_q == S_DONE_RTZ);

  always_comb begin
    // NOTE: every always_comb target is defaulted first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (ap_start_q) state_d = S_GO_REQ;
      S_GO_REQ:    if (go_0a)      state_d = S_GO_RTZ;
      S_GO_RTZ:    if (!go_0a)     state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (done_0r)    state_d = S_DONE_ACK;
      S_DONE_ACK:  if (!done_0r)   state_d = S_DONE_RTZ;
      S_DONE_RTZ:  state_d = auto_restart_q ? S_GO_REQ : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ap_start_d     = ap_start_q;
    ap_done_d      = ap_done_q;
    ap_ready_d     = ap_ready_q;
    auto_restart_d = auto_restart_q;
    gie_d          = gie_q;
    ier_d          = ier_q;
    isr_d          = isr_q;
    runcyc_d       = runcyc_q;
    reg_ack_d      = reg_accept;
    reg_rdata_d    = '0;

    if (reg_wr) begin
      unique case (reg_addr)
        ADDR_CTRL: begin
          if (reg_wdata[0] && state_q == S_IDLE) ap_start_d = 1'b1;
          auto_restart_d = reg_wdata[7];
        end
        ADDR_GIE: gie_d = reg_wdata[0];
        ADDR_IER: ier_d = reg_wdata[1:0];
        ADDR_ISR: isr_d = isr_q ^ reg_wdata[1:0];
        default: ;
      endcase
    end

    if (reg_rd) begin
      unique case (reg_addr)
        ADDR_CTRL: begin
          reg_rdata_d = {24'b0, auto_restart_q, 3'b0, ap_ready_q,
                         (state_q == S_IDLE), ap_done_q, ap_start_q};
          ap_done_d   = 1'b0;
          ap_ready_d  = 1'b0;
        end
        ADDR_GIE:    reg_rdata_d = {31'b0, gie_q};
        ADDR_IER:    reg_rdata_d = {30'b0, ier_q};
        ADDR_ISR:    reg_rdata_d = {30'b0, isr_q};
        ADDR_RUNCYC: reg_rdata_d = runcyc_q;
        default:     reg_rdata_d = '0;
      endcase
    end

    // Run completion overrides any same-edge clear-on-read or ISR toggle.
    if (run_end) begin
      ap_done_d  = 1'b1;
      ap_ready_d = 1'b1;
      isr_d      = isr_d | 2'b11;
      ap_start_d = auto_restart_q;
    end

    if (state_d == S_GO_REQ && state_q != S_GO_REQ) begin
      runcyc_d = '0;
    end else if (state_q != S_IDLE && runcyc_q != '1) begin
      runcyc_d = runcyc_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: the reset reaches every flop, outputs included, so handshake lines drop at once.
    if (!ap_rst_n) begin
      state_q        <= S_IDLE;
      ap_start_q     <= 1'b0;
      ap_done_q      <= 1'b0;
      ap_ready_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= 2'b0;
      isr_q          <= 2'b0;
      runcyc_q       <= '0;
      reg_ack_q      <= 1'b0;
      reg_rdata_q    <= '0;
      go_0r_q        <= 1'b0;
      done_0a_q      <= 1'b0;
      interrupt_q    <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      state_q        <= state_d;
      ap_start_q     <= ap_start_d;
      ap_done_q      <= ap_done_d;
      ap_ready_q     <= ap_ready_d;
      auto_restart_q <= auto_restart_d;
      gie_q          <= gie_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      runcyc_q       <= runcyc_d;
      reg_ack_q      <= reg_ack_d;
      reg_rdata_q    <= reg_rdata_d;
      go_0r_q        <= (state_d == S_GO_REQ);
      done_0a_q      <= (state_d == S_DONE_ACK);
      interrupt_q    <= gie_q & |(isr_q & ier_q);
    end
  end

  assign reg_ack   = reg_ack_q;
  assign reg_rdata = reg_rdata_q;
  assign go_0r     = go_0r_q;
  assign done_0a   = done_0a_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_sda_kernel_run_ctrl.sv
// Self-checking bench for sda_kernel_run_ctrl: directed run scenarios plus a
// randomized register test against a simple register model.
module tb_sda_kernel_run_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_write_en;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        go_0r;
  logic        go_0a;
  logic        done_0r;
  logic        done_0a;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  // Action-core responder controls and observed run length.
  bit rand_dly  = 1'b0;
  bit hold_done = 1'b0;
  int last_meas = 0;

  sda_kernel_run_ctrl #(.REG_ADDR_WIDTH(3)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .reg_req      (reg_req),
    .reg_ack      (reg_ack),
    .reg_write_en (reg_write_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .go_0r        (go_0r),
    .go_0a        (go_0a),
    .done_0r      (done_0r),
    .done_0a      (done_0a),
    .interrupt    (interrupt)
  );

  initial forever #5 ap_clk = ~ap_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Action core: acks go after a delay, raises done later, drops it once acked.
  // Also measures the non-IDLE span from first go_0r cycle to the DONE_RTZ cycle.
  initial begin
    int ph, cnt, meas;
    bit busy, prev_da;
    go_0a = 1'b0; done_0r = 1'b0;
    ph = 0; cnt = 0; meas = 0; busy = 1'b0; prev_da = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        ph = 0; go_0a = 1'b0; done_0r = 1'b0; busy = 1'b0; prev_da = 1'b0;
      end else begin
        if (go_0r && !busy) begin busy = 1'b1; meas = 0; end
        if (busy) meas++;
        if (busy && prev_da && !done_0a) begin busy = 1'b0; last_meas = meas; end
        prev_da = done_0a;
        case (ph)
          0: if (go_0r) begin cnt = rand_dly ? int'($urandom_range(1, 4)) : 2; ph = 1; end
          1: begin cnt--; if (cnt <= 0) begin go_0a = 1'b1; ph = 2; end end
          2: if (!go_0r) begin
               go_0a = 1'b0;
               cnt = rand_dly ? int'($urandom_range(3, 12)) : 10;
               ph = 3;
             end
          3: begin cnt--; if (cnt <= 0) begin done_0r = 1'b1; ph = 4; end end
          4: if (done_0a && !hold_done) begin done_0r = 1'b0; ph = 5; end
          5: if (!done_0a) ph = 0;
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic reg_xfer(input bit we, input int addr, input logic [31:0] wd,
                          input bit no_align, output logic [31:0] rd);
    int n;
    if (!no_align) @(negedge ap_clk);
    reg_req = 1'b1; reg_write_en = we; reg_addr = 3'(addr); reg_wdata = wd;
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!reg_ack && n < 8);
    rd = reg_rdata;
    reg_req = 1'b0; reg_write_en = 1'b0;
    check("ack_latency", n, 1);
  endtask

  task automatic wr(input int addr, input logic [31:0] wd);
    logic [31:0] dummy;
    reg_xfer(1'b1, addr, wd, 1'b0, dummy);
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    logic [31:0] v;
    reg_xfer(1'b0, addr, 32'h0, 1'b0, v);
    check(tag, v, exp);
  endtask

  // Returns at the negedge of the DONE_RTZ cycle (done_0a just fell).
  task automatic wait_rtz(input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!(seen && !done_0a) && n < 400) begin
      @(negedge ap_clk); n++;
      if (done_0a) seen = 1'b1;
    end
    check(tag, 32'(seen && !done_0a), 1);
  endtask

  task automatic wait_done_ack(input string tag);
    int n = 0;
    while (!done_0a && n < 400) begin @(negedge ap_clk); n++; end
    check(tag, 32'(done_0a), 1);
  endtask

  initial begin
    logic        gie_m;
    logic [1:0]  ier_m, isr_m;
    logic [31:0] runcyc_m, v, exp;
    int          a;
    bit          we;

    ap_rst_n = 1'b0; reg_req = 1'b0; reg_write_en = 1'b0;
    reg_addr = 3'd0; reg_wdata = 32'h0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Reset state
    check("rst_go_0r", go_0r, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_reg_ack", reg_ack, 0);
    check("rst_rdata", reg_rdata, 0);
    rd_chk("rst_ctrl", 0, 32'h4);
    rd_chk("rst_runcyc", 4, 32'h0);

    // Request held through the ack cycle is serviced once; rdata is 0 off-ack
    @(negedge ap_clk);
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 3'd0;
    @(negedge ap_clk);
    check("held_ack1", reg_ack, 1);
    check("held_rdata", reg_rdata, 32'h4);
    @(negedge ap_clk);
    check("held_ack0", reg_ack, 0);
    check("held_rdata0", reg_rdata, 0);
    reg_req = 1'b0;

    // Basic run with fixed core delays
    wr(0, 32'h1);
    @(negedge ap_clk);
    check("start_latency_go", go_0r, 1);
    wait_rtz("run1_done");
    rd_chk("run1_ctrl", 0, 32'h0E);
    rd_chk("run1_ctrl_again", 0, 32'h04);
    rd_chk("run1_runcyc", 4, 32'(last_meas));

    // Randomized register traffic against a model
    gie_m = 1'b0; ier_m = 2'b00; isr_m = 2'b11; runcyc_m = 32'(last_meas);
    for (int i = 0; i < 24; i++) begin
      a  = int'($urandom_range(1, 7));
      we = 1'($urandom_range(0, 1));
      v  = $urandom;
      if (we) begin
        wr(a, v);
        case (a)
          1: gie_m = v[0];
          2: ier_m = v[1:0];
          3: isr_m = isr_m ^ v[1:0];
          default: ;
        endcase
      end else begin
        case (a)
          1: exp = {31'b0, gie_m};
          2: exp = {30'b0, ier_m};
          3: exp = {30'b0, isr_m};
          4: exp = runcyc_m;
          default: exp = 32'h0;
        endcase
        rd_chk($sformatf("rand_rd_a%0d", a), a, exp);
      end
    end
    rd_chk("sweep_gie", 1, {31'b0, gie_m});
    rd_chk("sweep_ier", 2, {30'b0, ier_m});
    rd_chk("sweep_isr", 3, {30'b0, isr_m});
    rd_chk("sweep_a5", 5, 32'h0);
    rd_chk("sweep_a7", 7, 32'h0);

    // Clear interrupt sources
    wr(1, 32'h0); wr(2, 32'h0); wr(3, {30'b0, isr_m});
    rd_chk("isr_cleared", 3, 32'h0);
    repeat (2) @(negedge ap_clk);
    check("int_quiet", interrupt, 0);

    // Interrupt timing and ISR toggle
    wr(1, 32'h1); wr(2, 32'h1); wr(0, 32'h1);
    wait_rtz("int_run_done");
    @(negedge ap_clk);
    check("int_f1", interrupt, 0);
    @(negedge ap_clk);
    check("int_f2", interrupt, 1);
    wr(3, 32'h1);
    @(negedge ap_clk);
    check("int_cleared", interrupt, 0);
    wr(3, 32'h1);
    @(negedge ap_clk);
    check("int_reasserted", interrupt, 1);
    rd_chk("int_ctrl", 0, 32'h0E);
    wr(1, 32'h0); wr(3, 32'h3);

    // Auto-restart for three runs, then clear it mid-run
    rand_dly = 1'b1;
    wr(0, 32'h81);
    for (int r = 0; r < 3; r++) begin
      wait_rtz($sformatf("ar_run%0d_done", r));
      @(negedge ap_clk);
      check($sformatf("ar_rego%0d", r), go_0r, 1);
      rd_chk($sformatf("ar_ctrl%0d", r), 0, 32'h8B);
    end
    wr(0, 32'h0);
    wait_rtz("ar_last_done");
    @(negedge ap_clk);
    check("ar_stop_go", go_0r, 0);
    rd_chk("ar_stop_ctrl", 0, 32'h0E);
    rd_chk("ar_stop_runcyc", 4, 32'(last_meas));

    // CTRL read sampled on the very edge that sets ap_done
    wr(0, 32'h1);
    wait_rtz("race_done");
    reg_xfer(1'b0, 0, 32'h0, 1'b1, v);
    check("race_ctrl_pre", v, 32'h01);
    rd_chk("race_ctrl_post", 0, 32'h0E);

    // Reset while in DONE_ACK
    hold_done = 1'b1;
    wr(0, 32'h1);
    wait_done_ack("rst_mid_ack");
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_mid_done_0a", done_0a, 0);
    check("rst_mid_go_0r", go_0r, 0);
    check("rst_mid_ack", reg_ack, 0);
    check("rst_mid_int", interrupt, 0);
    hold_done = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    rd_chk("post_rst_ctrl", 0, 32'h04);
    rd_chk("post_rst_runcyc", 4, 32'h0);
    rd_chk("post_rst_isr", 3, 32'h0);
    wr(0, 32'h1);
    wait_rtz("post_rst_done");
    rd_chk("post_rst_run_ctrl", 0, 32'h0E);
    rd_chk("post_rst_run_cyc", 4, 32'(last_meas));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
